// File: rtl/clk_switch_ctrl.sv
// clk_switch_ctrl: drives the select line of a glitchless clock mux.
// Qualifies an external clock (seen as a CLK1/2 toggle) by counting its edges
// over fixed windows of the local oscillator clock. It moves to the external clock
// after enough consecutive good windows and falls back after one bad window.
// SEL is frozen for HOLDOFF cycles after every change.
// Ports:
//   i_clk          free-running oscillator clock (rising edge)
//   i_reset        synchronous active-high reset
//   i_ext_toggle   CLK1/2 toggle, asynchronous to i_clk
//   i_force_en     manual override enable
//   i_force_sel    target select while i_force_en=1
//   o_sel          mux select: 0 = local CLK0, 1 = external CLK1
//   o_ext_clk_ok   result of the last completed window
//   o_switching    high while SEL is frozen (HOLD)
//   o_switch_evt   one-cycle pulse in the cycle SEL changes
//   o_last_edges   edge count of the last completed window
module clk_switch_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned CNT_W         = 12,
  parameter int unsigned MIN_EDGES     = 480,
  parameter int unsigned MAX_EDGES     = 544,
  parameter int unsigned GOOD_WINDOWS  = 4,
  parameter int unsigned HOLDOFF       = 64
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ext_toggle,
  input  logic             i_force_en,
  input  logic             i_force_sel,
  output logic             o_sel,
  output logic             o_ext_clk_ok,
  output logic             o_switching,
  output logic             o_switch_evt,
  output logic [CNT_W-1:0] o_last_edges
);

  localparam int unsigned WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int unsigned GC_W  = (GOOD_WINDOWS > 0) ? $clog2(GOOD_WINDOWS + 1) : 1;
  localparam int unsigned HC_W  = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    ST_LOCAL = 2'd0,
    ST_EXT   = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [GC_W-1:0]  GC_FULL  = GC_W'(GOOD_WINDOWS);
  localparam logic [HC_W-1:0]  HC_LAST  = HC_W'(HOLDOFF - 1);

  logic [2:0]       r_sync;       // [0]=s1, [1]=s2, [2]=s3
  logic [WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0] r_edge_cnt;
  logic [CNT_W-1:0] r_last_edges;
  logic [GC_W-1:0]  r_good_cnt;
  logic             r_ext_clk_ok;
  logic             r_win_done;   // a window result became visible this cycle
  logic             r_force_en_d;
  state_t           r_state;
  logic             r_sel;
  logic [HC_W-1:0]  r_hold_cnt;
  logic             r_switch_evt;
  logic             r_switching;

  logic             w_edge;
  logic             w_win_end;
  logic [CNT_W-1:0] w_total;
  logic             w_good;
  logic             w_bad_done;
  logic             w_go_ext;
  logic             w_go_local;
  state_t           w_state_nxt;
  logic             w_sel_nxt;
  logic [HC_W-1:0]  w_hold_nxt;
  logic             w_evt_nxt;

  // Three-flop synchroniser; an edge is any change between s2 and s3.
  always_ff @(posedge i_clk) begin
    if (i_reset) r_sync <= '0;
    else         r_sync <= {r_sync[1:0], i_ext_toggle};
  end

  assign w_edge    = r_sync[1] ^ r_sync[2];
  assign w_win_end = (r_win_cnt == WIN_LAST);
  // Saturating count including the current edge; an edge on win_end closes the old window.
  assign w_total   = (r_edge_cnt == CNT_MAX) ? CNT_MAX : r_edge_cnt + CNT_W'(w_edge);
  assign w_good    = (32'(w_total) >= MIN_EDGES) && (32'(w_total) <= MAX_EDGES);

  // Measurement window and result registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_win_cnt    <= '0;
      r_edge_cnt   <= '0;
      r_last_edges <= '0;
      r_good_cnt   <= '0;
      r_ext_clk_ok <= 1'b0;
      r_win_done   <= 1'b0;
      r_force_en_d <= 1'b0;
    end else begin
      r_win_done   <= w_win_end;
      r_force_en_d <= i_force_en;
      if (w_win_end) begin
        r_win_cnt    <= '0;
        r_edge_cnt   <= '0;
        r_last_edges <= w_total;
        r_ext_clk_ok <= w_good;
        if (!w_good)                   r_good_cnt <= '0;
        else if (r_good_cnt != GC_FULL) r_good_cnt <= r_good_cnt + GC_W'(1);
      end else begin
        r_win_cnt  <= r_win_cnt + WIN_W'(1);
        r_edge_cnt <= w_total;
      end
    end
  end

  // Switch requests, evaluated one cycle after the window result lands.
  assign w_bad_done = r_win_done && !r_ext_clk_ok;
  assign w_go_ext   = (!i_force_en && (r_good_cnt == GC_FULL)) || (i_force_en && i_force_sel);
  assign w_go_local = (w_bad_done && !i_force_en) || (i_force_en && !i_force_sel) ||
                      (r_force_en_d && !i_force_en && (r_good_cnt < GC_FULL));

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= ST_LOCAL;
      r_sel        <= 1'b0;
      r_hold_cnt   <= '0;
      r_switch_evt <= 1'b0;
      r_switching  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_sel        <= w_sel_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_switch_evt <= w_evt_nxt;
      r_switching  <= (w_state_nxt == ST_HOLD);
    end
  end

  // FSM next state; loss of the external clock overrides an in-progress hold.
  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_hold_nxt  = r_hold_cnt;
    w_evt_nxt   = 1'b0;
    case (r_state)
      ST_LOCAL: begin
        if (w_go_ext) begin
          w_state_nxt = ST_HOLD;
          w_sel_nxt   = 1'b1;
          w_hold_nxt  = '0;
          w_evt_nxt   = 1'b1;
        end
      end
      ST_EXT: begin
        if (w_go_local) begin
          w_state_nxt = ST_HOLD;
          w_sel_nxt   = 1'b0;
          w_hold_nxt  = '0;
          w_evt_nxt   = 1'b1;
        end
      end
      ST_HOLD: begin
        if (r_sel && !i_force_en && w_bad_done) begin
          w_sel_nxt  = 1'b0;
          w_hold_nxt = '0;
          w_evt_nxt  = 1'b1;
        end else if (r_hold_cnt == HC_LAST) begin
          w_state_nxt = r_sel ? ST_EXT : ST_LOCAL;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + HC_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_LOCAL;
        w_sel_nxt   = 1'b0;
        w_hold_nxt  = '0;
      end
    endcase
  end

  assign o_sel        = r_sel;
  assign o_ext_clk_ok = r_ext_clk_ok;
  assign o_switching  = r_switching;
  assign o_switch_evt = r_switch_evt;
  assign o_last_edges = r_last_edges;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Bench for clk_switch_ctrl with a small window configuration.
module tb_clk_switch_ctrl;

  localparam int WIN   = 64;
  localparam int MINE  = 28;
  localparam int MAXE  = 36;
  localparam int GOODW = 4;
  localparam int HOLD  = 16;
  localparam int CMAX  = 4095;

  logic        clk;
  logic        i_reset, i_ext_toggle, i_force_en, i_force_sel;
  logic        o_sel, o_ext_clk_ok, o_switching, o_switch_evt;
  logic [11:0] o_last_edges;
  logic        s_sel, s_ok, s_sw, s_evt;
  logic [3:0]  s_last;

  clk_switch_ctrl #(.WINDOW_CYCLES(WIN), .CNT_W(12), .MIN_EDGES(MINE), .MAX_EDGES(MAXE),
                    .GOOD_WINDOWS(GOODW), .HOLDOFF(HOLD)) u_dut (
    .i_clk(clk), .i_reset(i_reset), .i_ext_toggle(i_ext_toggle),
    .i_force_en(i_force_en), .i_force_sel(i_force_sel),
    .o_sel(o_sel), .o_ext_clk_ok(o_ext_clk_ok), .o_switching(o_switching),
    .o_switch_evt(o_switch_evt), .o_last_edges(o_last_edges));

  // Narrow counter copy to exercise saturation.
  clk_switch_ctrl #(.WINDOW_CYCLES(WIN), .CNT_W(4), .MIN_EDGES(MINE), .MAX_EDGES(MAXE),
                    .GOOD_WINDOWS(GOODW), .HOLDOFF(HOLD)) u_sat (
    .i_clk(clk), .i_reset(i_reset), .i_ext_toggle(i_ext_toggle),
    .i_force_en(i_force_en), .i_force_sel(i_force_sel),
    .o_sel(s_sel), .o_ext_clk_ok(s_ok), .o_switching(s_sw),
    .o_switch_evt(s_evt), .o_last_edges(s_last));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: input history, window bookkeeping and a select/hold tracker.
  bit [2:0] m_hist;      // [0]=last sample, [1]=two ago, [2]=three ago
  int       m_phase, m_count, m_run, m_last, m_hold_left;
  bit       m_done, m_ok, m_sel, m_evt, m_fe_d;

  always @(posedge clk) begin : model_step
    bit e, good, bad_done;
    int total;
    if (i_reset) begin
      m_hist = '0; m_phase = 0; m_count = 0; m_run = 0; m_last = 0; m_hold_left = 0;
      m_done = 0; m_ok = 0; m_sel = 0; m_evt = 0; m_fe_d = 0;
    end else begin
      e = m_hist[1] ^ m_hist[2];
      bad_done = m_done && !m_ok;
      m_evt = 0;
      if (m_hold_left > 0) begin
        if (m_sel && !i_force_en && bad_done) begin
          m_sel = 0; m_hold_left = HOLD; m_evt = 1;
        end else begin
          m_hold_left--;
        end
      end else if (!m_sel) begin
        if ((!i_force_en && m_run == GOODW) || (i_force_en && i_force_sel)) begin
          m_sel = 1; m_hold_left = HOLD; m_evt = 1;
        end
      end else if ((bad_done && !i_force_en) || (i_force_en && !i_force_sel) ||
                   (m_fe_d && !i_force_en && m_run < GOODW)) begin
        m_sel = 0; m_hold_left = HOLD; m_evt = 1;
      end
      total = m_count + int'(e);
      if (total > CMAX) total = CMAX;
      if (m_phase == WIN - 1) begin
        good    = (total >= MINE) && (total <= MAXE);
        m_last  = total;
        m_ok    = good;
        m_run   = good ? ((m_run + 1 > GOODW) ? GOODW : m_run + 1) : 0;
        m_count = 0;
        m_done  = 1;
      end else begin
        m_count = total;
        m_done  = 0;
      end
      m_phase = (m_phase + 1) % WIN;
      m_fe_d  = i_force_en;
      m_hist  = {m_hist[1:0], i_ext_toggle};
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      n_checks++;
      if (o_sel !== m_sel || o_ext_clk_ok !== m_ok || o_switching !== (m_hold_left > 0) ||
          o_switch_evt !== m_evt || int'(o_last_edges) !== m_last) begin
        n_errors++;
        if (n_errors <= 20)
          $display("FAIL model t=%0t: got sel=%0b ok=%0b sw=%0b evt=%0b last=%0d, expected sel=%0b ok=%0b sw=%0b evt=%0b last=%0d",
                   $time, o_sel, o_ext_clk_ok, o_switching, o_switch_evt, o_last_edges,
                   m_sel, m_ok, (m_hold_left > 0), m_evt, m_last);
      end
    end
  end

  // Toggle generator: period 0 = static, else flip when glob is a multiple of cur_p.
  int glob = 0;
  int cur_p = 0;

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      if (cur_p != 0 && (glob % cur_p) == 0) i_ext_toggle = ~i_ext_toggle;
      glob++;
      @(negedge clk);
    end
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < 2 * WIN && m_phase != ph; i++) run_cycles(1);
    chk("phase_align", m_phase, ph);
  endtask

  typedef struct {
    int p; int nwin; int exp_last; int exp_ok; int exp_sel; int exp_sat;
  } vec_t;
  vec_t vecs[7];

  int evts, swc, pick, mode, fe_at, rst_at;

  initial begin
    vecs[0] = '{1, 2, 64, 0, 0, 15};  // too fast
    vecs[1] = '{4, 2, 16, 0, 0, 15};  // too slow
    vecs[2] = '{0, 2,  0, 0, 0,  0};  // static
    vecs[3] = '{2, 4, 32, 1, 0, 15};  // four good windows, switch not yet visible
    vecs[4] = '{2, 1, 32, 1, 1, 15};  // switched to external
    vecs[5] = '{0, 1,  1, 0, 1,  1};  // last in-flight edge lands in this window
    vecs[6] = '{0, 1,  0, 0, 0,  0};  // dropped back to local

    i_reset = 1; i_ext_toggle = 0; i_force_en = 0; i_force_sel = 0;
    repeat (3) @(negedge clk);
    chk("rst_sel", o_sel, 0);
    chk("rst_ok", o_ext_clk_ok, 0);
    chk("rst_switching", o_switching, 0);
    chk("rst_evt", o_switch_evt, 0);
    chk("rst_last", o_last_edges, 0);
    i_reset = 0; glob = 0; chk_en = 1;

    // Table of steady-rate windows.
    for (int v = 0; v < 7; v++) begin
      cur_p = vecs[v].p;
      run_cycles(vecs[v].nwin * WIN);
      chk($sformatf("vec%0d_last", v), o_last_edges, vecs[v].exp_last);
      chk($sformatf("vec%0d_ok", v), o_ext_clk_ok, vecs[v].exp_ok);
      chk($sformatf("vec%0d_sel", v), o_sel, vecs[v].exp_sel);
      chk($sformatf("vec%0d_sat_last", v), s_last, vecs[v].exp_sat);
      chk($sformatf("vec%0d_sat_flags", v), {s_sel, s_ok, s_sw, s_evt}, 0);
    end

    // Forced switch with a dead external clock, then release.
    cur_p = 0; i_force_en = 1; i_force_sel = 1;
    run_cycles(1);
    chk("force_sel", o_sel, 1);
    chk("force_evt", o_switch_evt, 1);
    chk("force_switching", o_switching, 1);
    run_cycles(20);
    chk("force_ext_sel", o_sel, 1);
    chk("force_ext_switching", o_switching, 0);
    i_force_en = 0;
    run_cycles(1);
    chk("release_sel", o_sel, 0);
    chk("release_evt", o_switch_evt, 1);
    run_cycles(16);
    chk("release_done", o_switching, 0);

    // Bad window landing inside HOLD after a 0->1 switch.
    run_to_phase(WIN - 4);
    evts = 0; swc = 0;
    i_force_en = 1; i_force_sel = 1;
    run_cycles(1); evts += int'(o_switch_evt);
    chk("hold_loss_up", o_sel, 1);
    i_force_en = 0; i_force_sel = 0;
    for (int i = 0; i < 3; i++) begin run_cycles(1); evts += int'(o_switch_evt); end
    chk("hold_loss_held", o_sel, 1);
    run_cycles(1); evts += int'(o_switch_evt);
    chk("hold_loss_drop", o_sel, 0);
    chk("hold_loss_switching", o_switching, 1);
    for (int i = 0; i < 20; i++) begin
      run_cycles(1); evts += int'(o_switch_evt); swc += int'(o_switching);
    end
    chk("hold_loss_evts", evts, 2);
    chk("hold_loss_restart_len", swc, HOLD - 1);

    // Reset in the middle of HOLD with SEL=1.
    run_cycles(20);
    i_force_en = 1; i_force_sel = 1;
    run_cycles(1);
    chk("midrst_pre_sel", o_sel, 1);
    run_cycles(5);
    i_reset = 1; i_force_en = 0; i_force_sel = 0;
    run_cycles(1);
    chk("midrst_sel", o_sel, 0);
    chk("midrst_switching", o_switching, 0);
    chk("midrst_evt", o_switch_evt, 0);
    chk("midrst_ok", o_ext_clk_ok, 0);
    chk("midrst_last", o_last_edges, 0);
    i_reset = 0;

    // Randomized windows against the model.
    for (int w = 0; w < 40; w++) begin
      pick = $urandom_range(0, 9);
      cur_p = (pick < 6) ? 2 : (pick == 6) ? 0 : (pick == 7) ? 1 : (pick == 8) ? 4 : 3;
      mode   = $urandom_range(0, 9);
      fe_at  = $urandom_range(0, WIN - 1);
      rst_at = $urandom_range(0, WIN - 1);
      for (int c = 0; c < WIN; c++) begin
        if ((mode == 7 || mode == 8) && c == fe_at) begin
          i_force_en  = ~i_force_en;
          i_force_sel = 1'($urandom_range(0, 1));
        end
        i_reset = (mode == 9 && c == rst_at);
        run_cycles(1);
      end
    end
    i_reset = 0;
    run_cycles(4);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
